peridot_servo_ramp: RTL and testbench
=====================================

// Module: peridot_servo_ramp
// PURPOSE
//  Next-generation multi-channel RC-servo (SG-90/MG-90S class) PWM generator on an Avalon-MM slave.
//  Adds per-frame slew-rate limiting: each channel's output position ramps toward a software target.
//  Channels are staggered in time to spread supply current. Sits on the PERIDOT peripheral bus.
// PARAMETERS
//  PWM_CHANNEL   16        number of servo channels, 1..32
//  CLOCKFREQ     25000000  csi_clk frequency in Hz
//  STEPCOUNTNUM  2560      steps per frame (20 ms frame)
//  UNITFREQ      128000    step rate in Hz; divider reload value = CLOCKFREQ/UNITFREQ-1, 12 bits
//  MINWIDTHSTEP  64        pulse width at position 0, in steps (0.5 ms)
//  STAGGERSTEP   320       start offset between channels; start(i) = (i%8)*STAGGERSTEP
// PORTS
//  csi_clk        in   1       clock, all logic on the rising edge
//  rsi_reset      in   1       reset; synchronous, active-high
//  avs_address    in   6       word address
//  avs_read       in   1       read strobe; readdata is valid 1 clock later
//  avs_readdata   out  32      read data
//  avs_write      in   1       write strobe; zero wait states
//  avs_writedata  in   32      write data
//  pwm_out        out  PWM_CHANNEL  servo pulse outputs, registered
//  dsm_out        out  PWM_CHANNEL  delta-sigma position outputs (see CONFIGURATION)
// BEHAVIOUR
//  Reset: avs_readdata, pwm_out, dsm_out and every register read 0; divider, step counter, accumulators = 0.
//  Register map:
//   0     CTRL: [0] ENA. Read {31'b0,ENA}.
//   1     RATE: [7:0] maximum position change per frame; 0 = no limit. Read {24'b0,RATE}.
//   2+i   channel i: write [7:0] = TARGET. Read {16'b0,CUR[7:0],TARGET[7:0]}.
//   Addresses >= 2+PWM_CHANNEL: writes ignored, reads return 0.
//  Divider: free-running 12-bit down-counter. tick = (div==0); on tick, reload to CLOCKDIV.
//  Step counter: 12 bits, runs while ENA=1.
//   - Advances on tick. Wraps from STEPCOUNTNUM-1 to 0.
//   - The wrap tick is frame_start.
//   - Forced to 0 while ENA=0.
//  Ramp, at frame_start only:
//   - RATE==0: CUR <= TARGET.
//   - |TARGET-CUR| <= RATE: CUR <= TARGET.
//   - Otherwise CUR moves toward TARGET by RATE.
//   - Use 9-bit signed difference; no overflow and no overshoot.
//  ENA=0: CUR tracks TARGET every clock, so the first frame after enable uses TARGET directly.
//  Write to TARGET or RATE on the same clock as frame_start: this ramp uses the old value; the new one applies next frame.
//  Pulse for channel i: high while ENA && step >= start(i) && step < start(i)+MINWIDTHSTEP+CUR.
//   - Defaults give a maximum end step of 2240+319 = 2559, so there is no wrap.
//   - pwm_out lags the step counter by 1 clock.
//  CUR is sampled only at frame_start, so the pulse width never changes mid-frame.
//  Writing ENA 1->0 drives all pwm_out low on the next clock. The step counter returns to 0.
//  Reset asserted mid-frame: on the next clock, all state and outputs return to reset values. No partial pulse after reset.
// CONFIGURATION
//  Macro PERIDOT_SERVO_RAMP_DSM_EN.
//   - Defined: per channel, a 9-bit first-order delta-sigma accumulator.
//     - acc <= acc[7:0] + CUR every clock; dsm_out[i] = registered acc[8].
//     - The accumulator is cleared while ENA=0.
//   - Undefined: no accumulators; dsm_out is tied to 0.
// TESTING
//  Use CLOCKFREQ=256000 (divider reload = 1, tick every 2 clocks).
//  1. Reset, then read all addresses -> 0. Read at addr 40 -> 0.
//  2. ENA=1, RATE=0, ch0 TARGET=0 -> pwm_out[0] high for 64 steps (128 clk) from step 0, repeating every 5120 clk.
//  3. ch1 TARGET=255 -> pwm_out[1] rises at step 320 and stays high for 319 steps.
//  4. RATE=16, CUR=0, TARGET=100 -> CUR reads 16,32,48,64,80,96,100 over 7 frames, then holds at 100.
//  5. Write TARGET on the frame_start clock -> that frame uses the old target.
//     Clear ENA mid-pulse -> pwm_out low on the next clock.
//  6. DSM_EN defined, CUR=64 -> dsm_out density 1/4, i.e. 64 highs per 256 clk. Undefined -> dsm_out constant 0.

Source files
------------

// File: rtl/peridot_servo_ramp.sv
// peridot_servo_ramp: multi-channel RC-servo PWM generator on an Avalon-MM slave.
// Each channel's position (CUR) slews toward a software TARGET once per 20 ms frame,
// limited by RATE. Channel pulse starts are staggered to spread supply current.
// Optional feature macro: PERIDOT_SERVO_RAMP_DSM_EN adds a per-channel first-order
// delta-sigma output of CUR on dsm_out; without it dsm_out is tied low.
module peridot_servo_ramp #(
  parameter int PWM_CHANNEL  = 16,
  parameter int CLOCKFREQ    = 25000000,
  parameter int STEPCOUNTNUM = 2560,
  parameter int UNITFREQ     = 128000,
  parameter int MINWIDTHSTEP = 64,
  parameter int STAGGERSTEP  = 320
) (
  input  logic                   csi_clk,
  input  logic                   rsi_reset,
  input  logic [5:0]             avs_address,
  input  logic                   avs_read,
  output logic [31:0]            avs_readdata,
  input  logic                   avs_write,
  input  logic [31:0]            avs_writedata,
  output logic [PWM_CHANNEL-1:0] pwm_out,
  output logic [PWM_CHANNEL-1:0] dsm_out
);

  localparam logic [11:0] DIV_RELOAD = 12'(CLOCKFREQ / UNITFREQ - 1);
  localparam logic [11:0] STEP_LAST  = 12'(STEPCOUNTNUM - 1);

  logic                   r_ena;
  logic [7:0]             r_rate;
  logic [11:0]            r_div;
  logic [11:0]            r_step;
  logic [PWM_CHANNEL-1:0] r_pwm;
  logic [31:0]            r_rdata;

  logic                   w_tick;
  logic                   w_frame_start;
  logic                   w_ena_nxt;
  logic [PWM_CHANNEL-1:0] w_pulse;
  logic [7:0]             w_cur [PWM_CHANNEL];
  logic [7:0]             w_tgt [PWM_CHANNEL];
  logic [31:0]            w_rdata;
  logic                   w_unused;

  assign w_unused      = &{1'b0, avs_writedata[31:8]};
  assign w_tick        = (r_div == 12'd0);
  assign w_frame_start = r_ena && w_tick && (r_step == STEP_LAST);
  // A write clearing ENA silences the outputs on the same edge it is taken.
  assign w_ena_nxt     = (avs_write && avs_address == 6'd0) ? avs_writedata[0] : r_ena;

  // Global control registers
  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      r_ena  <= 1'b0;
      r_rate <= 8'd0;
    end else if (avs_write) begin
      if (avs_address == 6'd0) r_ena  <= avs_writedata[0];
      if (avs_address == 6'd1) r_rate <= avs_writedata[7:0];
    end
  end

  // Free-running step-rate divider
  always_ff @(posedge csi_clk) begin
    if (rsi_reset)   r_div <= 12'd0;
    else if (w_tick) r_div <= DIV_RELOAD;
    else             r_div <= r_div - 12'd1;
  end

  // Step counter within the frame; held at 0 while disabled
  always_ff @(posedge csi_clk) begin
    if (rsi_reset || !r_ena) r_step <= 12'd0;
    else if (w_tick)         r_step <= (r_step == STEP_LAST) ? 12'd0 : r_step + 12'd1;
  end

  for (genvar i = 0; i < PWM_CHANNEL; i++) begin : g_ch
    localparam logic [12:0] START = 13'((i % 8) * STAGGERSTEP);

    logic              r_tgt;
    logic [7:0]        r_target;
    logic [7:0]        r_cur;
    logic              w_wsel;
    logic signed [8:0] w_diff;
    logic [8:0]        w_mag;
    logic [12:0]       w_end;

    assign r_tgt  = 1'b0;
    assign w_wsel = avs_write && (avs_address == 6'(i + 2));
    assign w_diff = $signed({1'b0, r_target}) - $signed({1'b0, r_cur});
    assign w_mag  = w_diff[8] ? 9'(-w_diff) : 9'(w_diff);
    assign w_end  = START + 13'(MINWIDTHSTEP) + {5'd0, r_cur};
    assign w_pulse[i] = r_ena && ({1'b0, r_step} >= START) && ({1'b0, r_step} < w_end);
    assign w_cur[i] = r_cur;
    assign w_tgt[i] = r_target;

    // Target register and once-per-frame slew-limited position update
    always_ff @(posedge csi_clk) begin
      if (rsi_reset) begin
        r_target <= 8'd0;
        r_cur    <= 8'd0;
      end else begin
        if (w_wsel) r_target <= avs_writedata[7:0];
        if (!r_ena) r_cur <= r_target;
        else if (w_frame_start) begin
          if (r_rate == 8'd0 || w_mag <= {1'b0, r_rate}) r_cur <= r_target;
          else if (w_diff[8])                             r_cur <= r_cur - r_rate;
          else                                            r_cur <= r_cur + r_rate;
        end
      end
    end

`ifdef PERIDOT_SERVO_RAMP_DSM_EN
    logic [8:0] r_acc;
    logic       r_dsm;

    // First-order delta-sigma of CUR; carry out is the bitstream
    always_ff @(posedge csi_clk) begin
      if (rsi_reset || !r_ena) begin
        r_acc <= 9'd0;
        r_dsm <= 1'b0;
      end else begin
        r_acc <= {1'b0, r_acc[7:0]} + {1'b0, r_cur};
        r_dsm <= r_acc[8];
      end
    end
    assign dsm_out[i] = r_dsm;
`endif
  end

`ifndef PERIDOT_SERVO_RAMP_DSM_EN
  assign dsm_out = '0;
`endif

  // Registered pulse outputs, one clock behind the step counter
  always_ff @(posedge csi_clk) begin
    if (rsi_reset) r_pwm <= '0;
    else           r_pwm <= w_ena_nxt ? w_pulse : '0;
  end

  // Read mux; unmapped addresses return 0
  always_comb begin
    w_rdata = 32'd0;
    if (avs_address == 6'd0) w_rdata = {31'd0, r_ena};
    if (avs_address == 6'd1) w_rdata = {24'd0, r_rate};
    for (int i = 0; i < PWM_CHANNEL; i++)
      if (avs_address == 6'(i + 2)) w_rdata = {16'd0, w_cur[i], w_tgt[i]};
  end

  // Read data is registered: valid one clock after the read strobe
  always_ff @(posedge csi_clk) begin
    if (rsi_reset)     r_rdata <= 32'd0;
    else if (avs_read) r_rdata <= w_rdata;
  end

  assign avs_readdata = r_rdata;
  assign pwm_out      = r_pwm;

endmodule

// File: tb/tb_peridot_servo_ramp.sv
// Directed bench for peridot_servo_ramp at CLOCKFREQ=256000 (tick every 2 clocks,
// 5120 clocks per frame). Inputs are driven and outputs sampled on the falling edge.
module tb_peridot_servo_ramp;
  localparam int NCH = 16;
  localparam int LIM = 12000;

  logic           clk = 1'b0;
  logic           rst;
  logic [5:0]     addr;
  logic           rd_s;
  logic           wr_s;
  logic [31:0]    wdata;
  logic [31:0]    rdata;
  logic [NCH-1:0] pwm;
  logic [NCH-1:0] dsm;

  int checks = 0;
  int errors = 0;

  peridot_servo_ramp #(.PWM_CHANNEL(NCH), .CLOCKFREQ(256000)) dut (
    .csi_clk(clk), .rsi_reset(rst), .avs_address(addr), .avs_read(rd_s),
    .avs_readdata(rdata), .avs_write(wr_s), .avs_writedata(wdata),
    .pwm_out(pwm), .dsm_out(dsm)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk); addr = a; wdata = d; wr_s = 1'b1;
    @(negedge clk); wr_s = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    @(negedge clk); addr = a; rd_s = 1'b1;
    @(negedge clk); rd_s = 1'b0; d = rdata;
  endtask

  // Wait for a fresh 0->1 transition on pwm_out[ch]
  task automatic wait_rise(input int ch);
    int n = 0;
    while (pwm[ch] === 1'b1 && n < LIM) begin n++; @(negedge clk); end
    while (pwm[ch] !== 1'b1 && n < LIM) begin n++; @(negedge clk); end
    if (n >= LIM) begin
      checks++; errors++;
      $display("FAIL rise_timeout ch%0d got no rise within %0d clk, need rise", ch, LIM);
    end
  endtask

  task automatic count_level(input int ch, input logic lvl, output int n);
    n = 0;
    while (pwm[ch] === lvl && n < LIM) begin n++; @(negedge clk); end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst = 1'b1; addr = '0; rd_s = 1'b0; wr_s = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (pwm !== '0 || dsm !== '0 || rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs got pwm=%h dsm=%h rd=%h need 0", pwm, dsm, rdata);
    end
    rst = 1'b0;
    for (int a = 0; a < NCH + 2; a++) begin
      rd(6'(a), d); checks++;
      if (d !== 32'd0) begin errors++; $display("FAIL reset_read a%0d got %h need 0", a, d); end
    end
    rd(6'd40, d); checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL read_a40 got %h need 0", d); end
  endtask

  task automatic test_basic_pulse;
    logic [31:0] d;
    int n;
    wr(6'd1, 32'd0);
    wr(6'd2, 32'd0);
    wr(6'd3, 32'd255);
    wr(6'd40, 32'd77);       // unmapped, must be ignored
    wr(6'd0, 32'd1);
    wait_rise(0);
    count_level(0, 1'b1, n); // first pulse may be short by the divider phase
    count_level(0, 1'b0, n); checks++;
    if (n !== 4992) begin errors++; $display("FAIL ch0_low got %0d clk need 4992", n); end
    count_level(0, 1'b1, n); checks++;
    if (n !== 128) begin errors++; $display("FAIL ch0_high got %0d clk need 128", n); end
    rd(6'd0, d); checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL ctrl_read got %h need 1", d); end
    rd(6'd3, d); checks++;
    if (d !== 32'h0000FFFF) begin errors++; $display("FAIL ch1_read got %h need 0000ffff", d); end
    rd(6'd40, d); checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL read_a40_after_wr got %h need 0", d); end
  endtask

  task automatic test_stagger;
    int n;
    wait_rise(0);
    count_level(1, 1'b0, n); checks++;
    if (n !== 640) begin errors++; $display("FAIL ch1_offset got %0d clk need 640", n); end
    count_level(1, 1'b1, n); checks++;
    if (n !== 638) begin errors++; $display("FAIL ch1_high got %0d clk need 638", n); end
  endtask

  task automatic test_ramp;
    logic [31:0] d;
    logic [7:0] exp_cur [8] = '{8'd16, 8'd32, 8'd48, 8'd64, 8'd80, 8'd96, 8'd100, 8'd100};
    wr(6'd0, 32'd0);
    wr(6'd4, 32'd0);
    wr(6'd1, 32'd16);
    wr(6'd0, 32'd1);
    wr(6'd4, 32'd100);
    rd(6'd1, d); checks++;
    if (d !== 32'd16) begin errors++; $display("FAIL rate_read got %h need 10", d); end
    for (int k = 0; k < 8; k++) begin
      wait_rise(0);
      rd(6'd4, d); checks++;
      if (d !== {16'd0, exp_cur[k], 8'd100}) begin
        errors++;
        $display("FAIL ramp_f%0d got %h need %h", k + 1, d, {16'd0, exp_cur[k], 8'd100});
      end
    end
  endtask

  task automatic test_frame_write_and_disable;
    logic [31:0] d;
    int n;
    wr(6'd1, 32'd0);
    wr(6'd5, 32'd50);
    wait_rise(0);                     // frame start: ch3 CUR becomes 50
    repeat (5118) @(negedge clk);     // last negedge before the next frame_start edge
    addr = 6'd5; wdata = 32'd200; wr_s = 1'b1;
    @(negedge clk); wr_s = 1'b0;
    rd(6'd5, d); checks++;
    if (d !== 32'h000032C8) begin errors++; $display("FAIL fs_write_read got %h need 000032c8", d); end
    count_level(3, 1'b0, n);
    count_level(3, 1'b1, n); checks++;
    if (n !== 228) begin errors++; $display("FAIL ch3_high got %0d clk need 228", n); end
    count_level(4, 1'b0, n);
    repeat (20) @(negedge clk);
    checks++;
    if (pwm[4] !== 1'b1) begin errors++; $display("FAIL ch4_mid got %b need 1", pwm[4]); end
    addr = 6'd0; wdata = 32'd0; wr_s = 1'b1;
    @(negedge clk); wr_s = 1'b0;
    checks++;
    if (pwm !== '0) begin errors++; $display("FAIL disable_low got %h need 0", pwm); end
  endtask

  task automatic test_dsm_and_mid_reset;
    logic [31:0] d;
    int n;
    int bad;
    int exp_hi;
    wr(6'd2, 32'd64);
    wr(6'd0, 32'd1);
    repeat (8) @(negedge clk);
`ifdef PERIDOT_SERVO_RAMP_DSM_EN
    exp_hi = 64;
`else
    exp_hi = 0;
`endif
    n = 0; bad = 0;
    for (int c = 0; c < 256; c++) begin
      if (dsm[0] === 1'b1) n++;
      if (exp_hi == 0 && dsm !== '0) bad++;
      @(negedge clk);
    end
    checks++;
    if (n !== exp_hi || bad !== 0) begin
      errors++; $display("FAIL dsm_density got %0d/256 (%0d nonzero) need %0d/256", n, bad, exp_hi);
    end
    count_level(1, 1'b0, n);
    repeat (20) @(negedge clk);
    checks++;
    if (pwm[1] !== 1'b1) begin errors++; $display("FAIL ch1_mid got %b need 1", pwm[1]); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (pwm !== '0 || dsm !== '0 || rdata !== 32'd0) begin
      errors++; $display("FAIL mid_reset got pwm=%h dsm=%h rd=%h need 0", pwm, dsm, rdata);
    end
    @(negedge clk); rst = 1'b0;
    rd(6'd0, d); checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL mid_reset_ctrl got %h need 0", d); end
    rd(6'd3, d); checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL mid_reset_ch1 got %h need 0", d); end
    bad = 0;
    for (int c = 0; c < 700; c++) begin
      if (pwm !== '0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL post_reset_pulse got %0d high clk need 0", bad); end
  endtask

  initial begin
    test_reset();
    test_basic_pulse();
    test_stagger();
    test_ramp();
    test_frame_write_and_disable();
    test_dsm_and_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
